// File: rtl/cec_pkg.sv
// Shared types and constants for the count-enable controller.
package cec_pkg;

    // Default width of the divide ratio and of the prescale counter.
    localparam int PRESCALE_W_DEFAULT = 8;

    // Width of the pulse counter and of the burst length.
    localparam int CNT_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    // Prescaler control issued by the FSM each cycle.
    typedef enum logic [1:0] {
        PS_HOLD    = 2'd0,
        PS_CLEAR   = 2'd1,
        PS_ADVANCE = 2'd2
    } ps_ctrl_t;

endpackage : cec_pkg

// File: rtl/cec_prescaler.sv
// Prescaler for the count-enable controller: holds the prescale counter and
// the captured divide ratio, and flags the cycle on which a pulse is due.
module cec_prescaler
    import cec_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  ps_ctrl_t              i_ctrl,
    input  logic [PRESCALE_W-1:0] i_div,
    output logic                  o_tc
);

    logic [PRESCALE_W-1:0] r_pc;
    logic [PRESCALE_W-1:0] r_div_q;

    // A pulse is due when the counter has reached the captured ratio.
    assign o_tc = (r_pc == r_div_q);

    // Clear captures a new ratio, advance counts or wraps, hold freezes.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks, so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_pc    <= '0;
            r_div_q <= '0;
        end else begin
            case (i_ctrl)
                PS_CLEAR: begin
                    r_pc    <= '0;
                    r_div_q <= i_div;
                end
                PS_ADVANCE: r_pc <= o_tc ? '0 : r_pc + PRESCALE_W'(1);
                default:    ;
            endcase
        end
    end

endmodule : cec_prescaler

// File: rtl/count_enable_ctrl.sv
// Count-enable controller: an IDLE/RUN/PAUSED FSM that issues one enable
// pulse every div+1 RUN cycles and counts them.
// Build option: define COUNT_ENABLE_CTRL_BURST_EN to end a run after
// burst_len pulses (burst_len == 0 stays unlimited) with a done pulse.
// Without it burst_len is ignored and done is tied low.
module count_enable_ctrl
    import cec_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [PRESCALE_W-1:0] div,
    input  logic [CNT_W-1:0]      burst_len,
    output logic                  enable,
    output logic                  busy,
    output logic                  paused,
    output logic                  done,
    output logic [CNT_W-1:0]      pulse_cnt
);

    state_t           r_state;
    state_t           w_next_state;
    ps_ctrl_t         w_ps_ctrl;
    logic             w_tc;
    logic             w_pulse;
    logic             w_done;
    logic             w_cnt_clear;
    logic [CNT_W-1:0] w_cnt_inc;

    logic             r_enable;
    logic             r_busy;
    logic             r_paused;
    logic [CNT_W-1:0] r_pulse_cnt;

    cec_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_ctrl (w_ps_ctrl),
        .i_div  (div),
        .o_tc   (w_tc)
    );

    assign w_cnt_inc = r_pulse_cnt + CNT_W'(1);

`ifdef COUNT_ENABLE_CTRL_BURST_EN
    logic [CNT_W-1:0] r_blen_q;
    logic             r_done;
    logic             w_burst_end;

    // The pulse that brings the count up to a nonzero limit ends the run.
    assign w_burst_end = (r_blen_q != '0) && (w_cnt_inc == r_blen_q);
`else
    logic w_burst_end;
    logic w_unused_burst_len;

    assign w_burst_end        = 1'b0;
    assign w_unused_burst_len = ^burst_len;
`endif

    // Next state, prescaler control and pulse decision; stop > pause > start.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_next_state = r_state;
        w_ps_ctrl    = PS_HOLD;
        w_pulse      = 1'b0;
        w_done       = 1'b0;
        w_cnt_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop && !pause) begin
                    w_next_state = RUN;
                    w_ps_ctrl    = PS_CLEAR;
                    w_cnt_clear  = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (pause) begin
                    w_next_state = PAUSED;
                end else begin
                    w_ps_ctrl = PS_ADVANCE;
                    if (w_tc) begin
                        w_pulse = 1'b1;
                        if (w_burst_end) begin
                            w_done       = 1'b1;
                            w_next_state = IDLE;
                        end
                    end
                end
            end
            PAUSED: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (!pause && start) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register and registered status/pulse outputs.
    always_ff @(posedge clk) begin
        // NOTE: datapath flops are reset along with control so every output
        // is defined from the first cycle; there is no storage array here.
        if (rst) begin
            r_state     <= IDLE;
            r_enable    <= 1'b0;
            r_busy      <= 1'b0;
            r_paused    <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_enable <= w_pulse;
            r_busy   <= (w_next_state != IDLE);
            r_paused <= (w_next_state == PAUSED);
            if (w_cnt_clear) begin
                r_pulse_cnt <= '0;
            end else if (w_pulse) begin
                r_pulse_cnt <= w_cnt_inc;
            end
        end
    end

`ifdef COUNT_ENABLE_CTRL_BURST_EN
    // Burst limit capture and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blen_q <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_cnt_clear) begin
                r_blen_q <= burst_len;
            end
        end
    end

    assign done = r_done;
`else
    logic w_unused_done;

    assign w_unused_done = w_done;
    assign done          = 1'b0;
`endif

    assign enable    = r_enable;
    assign busy      = r_busy;
    assign paused    = r_paused;
    assign pulse_cnt = r_pulse_cnt;

endmodule : count_enable_ctrl

// File: tb/tb_count_enable_ctrl.sv
// Testbench for count_enable_ctrl: the stimulus process pushes the expected
// cycle, count and done flag of every enable pulse into a scoreboard; a
// monitor pops one entry each time enable is seen high.
module tb_count_enable_ctrl;

`ifdef COUNT_ENABLE_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] div;
    logic [7:0] burst_len;
    logic       enable;
    logic       busy;
    logic       paused;
    logic       done;
    logic [7:0] pulse_cnt;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    count_enable_ctrl #(
        .PRESCALE_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .div       (div),
        .burst_len (burst_len),
        .enable    (enable),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push(input int c, input int cnt, input logic d);
        exp_t e;
        e.cyc  = c;
        e.cnt  = 8'(cnt);
        e.done = d;
        sb_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_paused"}, paused, 0);
    endtask

    // Monitor: every enable pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (enable === 1'b1) begin
                check("pulse_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_cnt", pulse_cnt, e.cnt);
                    check("pulse_done", done, e.done);
                end
            end else if (done === 1'b1) begin
                check("done_without_enable", done, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0;
        div = 8'd0; burst_len = 8'd0;

        // Reset overrides a pending start.
        repeat (3) tick();
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_paused", paused, 0);
        check("rst_done", done, 0);
        check("rst_pulse_cnt", pulse_cnt, 0);
        rst = 1'b0; start = 1'b0;
        repeat (2) tick();
        check_idle("idle");

        // div=3 unlimited: pulses at +5, +9, +13; mid-run div/burst changes
        // and a repeated start are ignored.
        div = 8'd3; burst_len = 8'd0;
        c = cyc; start = 1'b1;
        for (int i = 0; i < 3; i++) push(c + 5 + 4 * i, i + 1, 1'b0);
        tick(); start = 1'b0;
        check("div3_busy", busy, 1);
        check("div3_paused", paused, 0);
        div = 8'd7; burst_len = 8'd1;
        wait_until(c + 6); start = 1'b1; tick(); start = 1'b0;
        wait_until(c + 14); stop = 1'b1; tick(); stop = 1'b0;
        check_idle("div3_stop");

        // div=0 burst_len=4: four back-to-back pulses; with the burst option
        // the fourth carries done and ends the run, otherwise stop ends it
        // and suppresses the fifth.
        div = 8'd0; burst_len = 8'd4;
        c = cyc; start = 1'b1;
        for (int i = 0; i < 4; i++) push(c + 2 + i, i + 1, BURST && (i == 3));
        tick(); start = 1'b0;
        wait_until(c + 5); stop = 1'b1; tick(); stop = 1'b0;
        check("burst_busy_after", busy, 0);
        check("burst_done_after", done, 0);
        check("burst_cnt_hold", pulse_cnt, 4);

        // div=2: pause on a due pulse suppresses it; resume five cycles
        // later gives a pulse one cycle after resuming, then every 3.
        div = 8'd2; burst_len = 8'd0;
        c = cyc; start = 1'b1;
        push(c + 4, 1, 1'b0);  push(c + 7, 2, 1'b0);
        push(c + 16, 3, 1'b0); push(c + 19, 4, 1'b0); push(c + 22, 5, 1'b0);
        tick(); start = 1'b0;
        wait_until(c + 9); pause = 1'b1; tick(); pause = 1'b0;
        check("pause_paused", paused, 1);
        check("pause_busy", busy, 1);
        wait_until(c + 14); start = 1'b1; tick(); start = 1'b0;
        check("resume_paused", paused, 0);
        check("resume_busy", busy, 1);
        wait_until(c + 22); stop = 1'b1; tick(); stop = 1'b0;
        check_idle("pause_stop");

        // stop+pause in RUN goes to IDLE; stop+start in PAUSED goes to IDLE.
        div = 8'd1;
        c = cyc; start = 1'b1;
        tick(); start = 1'b0;
        tick(); stop = 1'b1; pause = 1'b1;
        tick(); stop = 1'b0; pause = 1'b0;
        check_idle("stop_pause_run");
        start = 1'b1;
        tick(); start = 1'b0; pause = 1'b1;
        tick(); pause = 1'b0;
        check("pause_again_paused", paused, 1);
        stop = 1'b1; start = 1'b1;
        tick(); stop = 1'b0; start = 1'b0;
        check_idle("stop_start_paused");

        // Reset mid-burst: five pulses, reset clears everything, a new run
        // counts from 1.
        div = 8'd0; burst_len = 8'd10;
        c = cyc; start = 1'b1;
        for (int i = 0; i < 5; i++) push(c + 2 + i, i + 1, 1'b0);
        tick(); start = 1'b0;
        wait_until(c + 6); rst = 1'b1; tick();
        check("midrst_enable", enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_paused", paused, 0);
        check("midrst_done", done, 0);
        check("midrst_pulse_cnt", pulse_cnt, 0);
        rst = 1'b0; start = 1'b1;
        push(c + 9, 1, 1'b0); push(c + 10, 2, 1'b0);
        tick(); start = 1'b0;
        wait_until(c + 10); stop = 1'b1; tick(); stop = 1'b0;
        check_idle("midrst_restart_stop");

        // Continuous div=0 run of 260 pulses: pulse_cnt wraps 255 -> 0.
        // Without the burst option burst_len=2 must be ignored.
        div = 8'd0; burst_len = BURST ? 8'd0 : 8'd2;
        c = cyc; start = 1'b1;
        for (int i = 0; i < 260; i++) push(c + 2 + i, (i + 1) % 256, 1'b0);
        tick(); start = 1'b0;
        wait_until(c + 261); stop = 1'b1; tick(); stop = 1'b0;
        check_idle("wrap_stop");
        check("wrap_cnt", pulse_cnt, 4);

        repeat (4) tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_count_enable_ctrl

// File: doc/count_enable_ctrl.md
COUNT_ENABLE_CTRL -- requirements
Module: count_enable_ctrl

Interface
REQ-001 Parameter: PRESCALE_W, default 8, width of the divide-ratio input and the internal prescale counter.
REQ-002 Port: clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  level-sampled command; begins a run from IDLE, resumes from PAUSED.
REQ-005 Port: stop  input  1  level-sampled command; aborts to IDLE.
REQ-006 Port: pause  input  1  level-sampled command; suspends RUN.
REQ-007 Port: div  input  PRESCALE_W  divide ratio; one enable pulse every div+1 RUN cycles.
REQ-008 Port: burst_len  input  8  number of pulses per run; 0 means unlimited.
REQ-009 Port: enable  output  1  registered one-cycle pulse driving the downstream counter's enable.
REQ-010 Port: busy  output  1  registered; high in RUN or PAUSED.
REQ-011 Port: paused  output  1  registered; high in PAUSED.
REQ-012 Port: done  output  1  registered one-cycle pulse marking burst completion.
REQ-013 Port: pulse_cnt  output  8  registered count of enable pulses issued in the current run.

Function
REQ-014 States SHALL be IDLE, RUN, PAUSED; command priority SHALL be stop > pause > start.
REQ-015 IDLE: start SHALL go to RUN, clear the prescale counter (pc) and pulse_cnt, and latch div into div_q and burst_len into blen_q.
REQ-016 RUN: stop SHALL go to IDLE; else pause SHALL go to PAUSED; otherwise stay in RUN.
REQ-017 PAUSED: stop SHALL go to IDLE; else start SHALL go to RUN, keeping pc, pulse_cnt, div_q and blen_q.
REQ-018 Each cycle in RUN with no stop or pause: if pc == div_q, enable SHALL be 1, pc SHALL clear to 0, and pulse_cnt SHALL increment; otherwise enable SHALL be 0 and pc SHALL increment.
REQ-019 Latency: for start sampled at edge k, the first enable SHALL be high in the cycle after edge k+1+div_q; the period SHALL be div_q+1 cycles; div=0 SHALL give enable every RUN cycle.
REQ-020 A stop or pause in a cycle that would issue a pulse SHALL suppress it: enable 0, pc unchanged on pause.
REQ-021 enable SHALL be 0 in IDLE and PAUSED; changes to div or burst_len mid-run SHALL have no effect until the next start from IDLE.
REQ-022 pulse_cnt SHALL wrap 255 -> 0 without side effects when blen_q == 0.
REQ-023 start while in RUN, or stop/pause while in IDLE, SHALL be ignored.

Reset
REQ-024 rst SHALL override all inputs: state IDLE; enable, busy, paused and done 0; pc, pulse_cnt, div_q and blen_q 0.
REQ-025 rst asserted mid-run SHALL abort with no done pulse.

Configuration
REQ-026 Macro COUNT_ENABLE_CTRL_BURST_EN defined: when a pulse makes pulse_cnt equal nonzero blen_q, that same edge SHALL set enable=1 and done=1 and go to IDLE.
REQ-027 Macro undefined: burst_len SHALL be ignored, runs SHALL be unlimited, done SHALL be constant 0, and the port list SHALL be unchanged.

Structure
REQ-028 Shared package cec_pkg SHALL hold the state typedef (IDLE/RUN/PAUSED) and the PRESCALE_W default constant.
REQ-029 Sub-module cec_prescaler SHALL hold pc, div_q and the terminal-count compare, with clear/hold/advance controls from the FSM.

Verification
REQ-030 div=3, burst_len=0, start pulse at cycle 0 -> enable high at cycles 5, 9, 13, ...; busy=1 from cycle 1.
REQ-031 div=0, burst_len=4, macro defined -> enable high for 4 consecutive cycles; done=1 with the 4th pulse; busy=0 the next cycle; pulse_cnt=4.
REQ-032 div=2, pause in the cycle a pulse is due, start 5 cycles later -> no enable while paused; next pulse 1 cycle after resume; spacing is 3 thereafter.
REQ-033 Stop and pause asserted together in RUN -> IDLE, no PAUSED; stop and start together in PAUSED -> IDLE.
REQ-034 rst asserted mid-burst (burst_len=10 after 5 pulses) -> all outputs 0 the next cycle, no done; a new start gives pulse_cnt counting from 1.
REQ-035 Macro undefined, burst_len=2, div=0 -> enable continuous past 2 pulses; done stays 0; pulse_cnt wraps 255 -> 0.
